// File: rtl/fp_mul_result_fifo.sv
// First-word-fall-through result FIFO behind the FP multiplier, with saturating NaN/Inf counters.
// Optional FP_MUL_RESULT_FLUSH_DENORM_EN: store pushed denormals as signed zero.
module fp_mul_result_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [AW:0]       level,
  output logic [CNT_W-1:0]  nan_count,
  output logic [CNT_W-1:0]  inf_count,
  input  logic              clr_counts
);

  localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [CNT_W-1:0]  nan_cnt_q, nan_cnt_d;
  logic [CNT_W-1:0]  inf_cnt_q, inf_cnt_d;

  logic              push, pop;
  logic              exp_all_ones, exp_zero, mant_zero;
  logic              is_nan, is_inf;
  logic [DATA_W-1:0] wr_data;

  // Flags depend only on registered level, so no path from m_axis_tready to s_axis_tready.
  assign s_axis_tready = (level_q != LevelFull);
  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign level         = level_q;
  assign nan_count     = nan_cnt_q;
  assign inf_count     = inf_cnt_q;

  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  assign exp_all_ones = (s_axis_tdata[30:23] == 8'hFF);
  assign exp_zero     = (s_axis_tdata[30:23] == 8'h00);
  assign mant_zero    = (s_axis_tdata[22:0] == 23'd0);
  assign is_nan       = push & exp_all_ones & ~mant_zero;
  assign is_inf       = push & exp_all_ones & mant_zero;

  always_comb begin
    wr_data = s_axis_tdata;
`ifdef FP_MUL_RESULT_FLUSH_DENORM_EN
    if (exp_zero && !mant_zero) begin
      wr_data = {s_axis_tdata[DATA_W-1], {(DATA_W-1){1'b0}}};
    end
`else
    if (exp_zero && !mant_zero) begin
      wr_data = s_axis_tdata;
    end
`endif
  end

  // A clear still counts an event arriving in the same cycle.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur, input logic ev,
                                                input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = ev ? CNT_W'(1) : '0;
    end else if (ev && (cur != '1)) begin
      nxt = cur + CNT_W'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
    nan_cnt_d = cnt_next(nan_cnt_q, is_nan, clr_counts);
    inf_cnt_d = cnt_next(inf_cnt_q, is_inf, clr_counts);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      nan_cnt_q <= '0;
      inf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      nan_cnt_q <= nan_cnt_d;
      inf_cnt_q <= inf_cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fp_mul_result_fifo.sv
// Self-checking bench for fp_mul_result_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fp_mul_result_fifo;

  localparam int DEPTH   = 8;
  localparam int CNT_MAX = 65535;

  logic        clock = 1'b0;
  logic        rstn;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  level;
  logic [15:0] nan_count;
  logic [15:0] inf_count;
  logic        clr_counts;

  always #5 clock = ~clock;

  fp_mul_result_fifo dut (
    .clock         (clock),
    .rstn          (rstn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .level         (level),
    .nan_count     (nan_count),
    .inf_count     (inf_count),
    .clr_counts    (clr_counts)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue, counters as plain integers.
  logic [31:0] mq[$];
  int          m_nan;
  int          m_inf;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    int          nan_inc;
    int          inf_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef FP_MUL_RESULT_FLUSH_DENORM_EN
    if (w[30:23] == 8'h00 && w[22:0] != 23'd0) return {w[31], 31'd0};
`endif
    return w;
  endfunction

  task automatic compare_model();
    check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, mq.size() != 0});
    check("tready", {31'd0, s_axis_tready}, {31'd0, mq.size() != DEPTH});
    check("level", {28'd0, level}, mq.size());
    if (mq.size() != 0) check("tdata", m_axis_tdata, mq[0]);
    check("nan_count", {16'd0, nan_count}, m_nan);
    check("inf_count", {16'd0, inf_count}, m_inf);
  endtask

  // Advance one clock: model decides push/pop from its own occupancy, then compares.
  task automatic step();
    bit push, pop, isn, isi;
    push = s_axis_tvalid && (mq.size() != DEPTH);
    pop  = m_axis_tready && (mq.size() != 0);
    isn  = push && s_axis_tdata[30:23] == 8'hFF && s_axis_tdata[22:0] != 0;
    isi  = push && s_axis_tdata[30:23] == 8'hFF && s_axis_tdata[22:0] == 0;
    @(posedge clock);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(stored(s_axis_tdata));
    if (clr_counts) begin
      m_nan = isn ? 1 : 0;
      m_inf = isi ? 1 : 0;
    end else begin
      if (isn && m_nan < CNT_MAX) m_nan++;
      if (isi && m_inf < CNT_MAX) m_inf++;
    end
    #1;
    compare_model();
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    clr_counts    = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    idle();
    m_axis_tready = 1'b1;
    while (mq.size() != 0 && guard < 4 * DEPTH) begin
      step();
      guard++;
    end
    check("drain_empty", {31'd0, m_axis_tvalid}, 32'd0);
    idle();
  endtask

  task automatic push_word(input logic [31:0] w, input logic rdy);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = w;
    m_axis_tready = rdy;
    step();
  endtask

  initial begin
    logic [31:0] w;
    int          nan0, inf0;

    vecs[0] = '{32'h3F800000, 32'h3F800000, 0, 0};
    vecs[1] = '{32'h7FC00000, 32'h7FC00000, 1, 0};
    vecs[2] = '{32'h7F800000, 32'h7F800000, 0, 1};
    vecs[3] = '{32'hFF800000, 32'hFF800000, 0, 1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0};
`ifdef FP_MUL_RESULT_FLUSH_DENORM_EN
    vecs[5] = '{32'h80000001, 32'h80000000, 0, 0};
    vecs[6] = '{32'h007FFFFF, 32'h00000000, 0, 0};
`else
    vecs[5] = '{32'h80000001, 32'h80000001, 0, 0};
    vecs[6] = '{32'h007FFFFF, 32'h007FFFFF, 0, 0};
`endif
    vecs[7] = '{32'h80000000, 32'h80000000, 0, 0};

    m_nan = 0;
    m_inf = 0;
    s_axis_tdata = '0;
    idle();
    rstn = 1'b0;
    #1;
    compare_model();
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;

    // Two words with consumer ready: each visible the cycle after its push.
    push_word(32'h3F800000, 1'b1);
    check("t1_first", m_axis_tdata, 32'h3F800000);
    push_word(32'h40000000, 1'b1);
    check("t1_second", m_axis_tdata, 32'h40000000);
    idle();
    m_axis_tready = 1'b1;
    step();
    check("t1_level", {28'd0, level}, 32'd0);
    check("t1_tready", {31'd0, s_axis_tready}, 32'd1);

    // Fill to full, hold off 9th, one pop gives tready back a cycle later.
    for (int i = 1; i <= DEPTH; i++) push_word(i, 1'b0);
    check("t2_full_tready", {31'd0, s_axis_tready}, 32'd0);
    check("t2_full_level", {28'd0, level}, DEPTH);
    push_word(32'h9, 1'b0);
    check("t2_held_level", {28'd0, level}, DEPTH);
    check("t2_head_stable", m_axis_tdata, 32'h1);
    push_word(32'h9, 1'b1);
    check("t2_bubble_tready", {31'd0, s_axis_tready}, 32'd1);
    check("t2_bubble_level", {28'd0, level}, DEPTH - 1);
    check("t2_next_head", m_axis_tdata, 32'h2);
    drain();

    // Steady push+pop at level 3 across pointer wrap.
    for (int i = 0; i < 3; i++) push_word(32'h100 + i, 1'b0);
    for (int i = 0; i < 20; i++) begin
      push_word(32'h200 + i, 1'b1);
      check("t3_level", {28'd0, level}, 32'd3);
    end
    drain();

    // Classification table, one isolated word at a time.
    for (int i = 0; i < 8; i++) begin
      nan0 = m_nan;
      inf0 = m_inf;
      push_word(vecs[i].din, 1'b0);
      check("vec_dout", m_axis_tdata, vecs[i].dout);
      check("vec_nan", {16'd0, nan_count}, nan0 + vecs[i].nan_inc);
      check("vec_inf", {16'd0, inf_count}, inf0 + vecs[i].inf_inc);
      drain();
    end

    // Counter values and clear coinciding with a push.
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    push_word(32'h7FC00000, 1'b1);
    push_word(32'h7F800000, 1'b1);
    push_word(32'hFF800000, 1'b1);
    push_word(32'h7F800001, 1'b1);
    check("cnt_nan2", {16'd0, nan_count}, 32'd2);
    check("cnt_inf2", {16'd0, inf_count}, 32'd2);
    clr_counts = 1'b1;
    push_word(32'h7FC00000, 1'b1);
    clr_counts = 1'b0;
    check("clr_nan1", {16'd0, nan_count}, 32'd1);
    check("clr_inf0", {16'd0, inf_count}, 32'd0);
    drain();

    // Saturation: walk nan_count up to 0xFFFE, then three more.
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    for (int i = 0; i < 32'hFFFE; i++) push_word(32'h7FC00001, 1'b1);
    check("sat_fffe", {16'd0, nan_count}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) push_word(32'hFFC00000, 1'b1);
    check("sat_ffff", {16'd0, nan_count}, 32'h0000FFFF);
    push_word(32'h7FC00000, 1'b1);
    check("sat_hold", {16'd0, nan_count}, 32'h0000FFFF);
    drain();

    // Asynchronous reset with five words queued.
    for (int i = 0; i < 5; i++) push_word(32'h7F800000 + i, 1'b0);
    check("rst_pre_level", {28'd0, level}, 32'd5);
    idle();
    #3 rstn = 1'b0;
    #1;
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_nan", {16'd0, nan_count}, 32'd0);
    check("rst_inf", {16'd0, inf_count}, 32'd0);
    mq.delete();
    m_nan = 0;
    m_inf = 0;
    @(negedge clock);
    rstn = 1'b1;
    @(posedge clock);
    #1;
    compare_model();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      case ($urandom % 8)
        0: begin w[30:23] = 8'hFF; if (w[22:0] == 0) w[0] = 1'b1; end
        1: begin w[30:23] = 8'hFF; w[22:0] = '0; end
        2: begin w[30:23] = 8'h00; if (w[22:0] == 0) w[5] = 1'b1; end
        default: ;
      endcase
      s_axis_tvalid = ($urandom % 4) != 0;
      s_axis_tdata  = w;
      m_axis_tready = ($urandom % 3) != 0;
      clr_counts    = ($urandom % 64) == 0;
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_result_fifo.md
Name: fp_mul_result_fifo

Overview:
- Downstream stage of the single-precision FP multiplier; consumes its AXI-stream result channel (m_axis_result_*).
- Buffers products in a first-word-fall-through FIFO so a slow consumer can stall without stalling the multiplier pipeline.
- Classifies each accepted word and keeps saturating NaN/Inf event counters for the status/debug path.

Parameters:
- DATA_W, 32, word width; fixed IEEE-754 single layout: sign[31], exp[30:23], mant[22:0].
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, log2(DEPTH); pointer width.
- CNT_W, 16, width of the event counters.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  result valid from multiplier.
- s_axis_tready  out  1  FIFO can accept; drives multiplier m_axis_result_tready.
- s_axis_tdata  in  DATA_W  product word.
- m_axis_tvalid  out  1  head word valid.
- m_axis_tready  in  1  consumer accepts head.
- m_axis_tdata  out  DATA_W  head word.
- level  out  AW+1  current occupancy, 0..DEPTH.
- nan_count  out  CNT_W  accepted words with exp=0xFF and mant!=0.
- inf_count  out  CNT_W  accepted words with exp=0xFF and mant==0.
- clr_counts  in  1  synchronous clear of both counters.

Behaviour:
- Reset (rstn low, asynchronous): read/write pointers=0, level=0, nan_count=0, inf_count=0, m_axis_tvalid=0, s_axis_tready=1 from the assertion edge on. Stored data is don't-care. Reset mid-transfer discards all contents; no partial word is ever presented.
- Push = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready.
- s_axis_tready = (level != DEPTH), decoded from registers only. No combinational path from m_axis_tready.
- m_axis_tvalid = (level != 0). m_axis_tdata = mem[rd_ptr], first-word-fall-through.
- Latency: a word pushed into an empty FIFO at edge N is valid on m_axis at N+1. A push cannot bypass to the output in the same cycle.
- Push only: level+1. Pop only: level-1. Push+pop together: level unchanged, both pointers advance.
- Full: tready=0, so no push occurs. A pop while full frees one slot, and tready rises the next cycle (one bubble by design).
- Empty: tvalid=0; m_axis_tready is ignored.
- Pointers are AW bits and wrap DEPTH-1 -> 0 naturally; order is preserved across wrap.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata holds stable (AXI-stream rule).
- Counters:
  - Increment on push only, classified from s_axis_tdata as written.
  - Saturate at 2^CNT_W-1 and never wrap.
  - clr_counts=1: each counter loads 1 if a matching push happens that cycle, else 0. No event is lost.
- No reordering, dropping or modification of data except as given under Optional Feature.

Optional Feature:
- Macro: FP_MUL_RESULT_FLUSH_DENORM_EN.
- Defined: any pushed word with exp==0 and mant!=0 is stored as {sign,31'b0} (sign-preserving flush to zero); classification and counters are unaffected.
- Undefined: denormals are stored and output bit-exact.

Test Plan:
- Reset then push 0x3F800000, 0x40000000, consumer ready -> m_axis shows 0x3F800000 one cycle after its push, then 0x40000000; level returns to 0; tready stays 1.
- m_axis_tready=0, push 8 words 0x00000001..0x00000008 -> level=8, s_axis_tready=0 after the 8th push, 9th word held off. Pop one -> tready=1 the next cycle; all 8 words drain in order.
- Continuous push+pop for 20 words with consumer always ready, starting at level 3 -> level stays 3; output order matches input across pointer wrap.
- Push 0x7FC00000, 0x7F800000, 0xFF800000, 0x7F800001 -> nan_count=2, inf_count=2. clr_counts asserted in the same cycle as a 0x7FC00000 push -> nan_count=1, inf_count=0.
- Force nan_count to 0xFFFE, push 3 NaNs -> nan_count=0xFFFF and holds. Assert rstn low mid-stream with level=5 -> level=0 and m_axis_tvalid=0 immediately, counters 0.
- Macro defined: push 0x80000001 -> output 0x80000000. Macro undefined: push 0x80000001 -> output 0x80000001.
